// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and default datapath widths.
// Imported by the operand-issue stage and its register file.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_SRL = 3'b100;
  localparam logic [OP_W-1:0] OP_SRA = 3'b101;

endpackage

// File: rtl/grf_core.sv
// General register file: one write port, two bypassed read ports,
// register 0 hardwired to zero.
module grf_core
  import alu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] mem [NREG];
  logic          wr;

  assign wr = wb_en && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (wr) begin
      mem[wb_addr] <= wb_data;
    end
  end

  // Same-cycle writeback wins over the stored value.
  always_comb begin
    ra_data = '0;
    unique case (1'b1)
      (ra_addr == '0):           ra_data = '0;
      (wr && wb_addr == ra_addr): ra_data = wb_data;
      default:                   ra_data = mem[ra_addr];
    endcase
  end

  always_comb begin
    rb_data = '0;
    unique case (1'b1)
      (rb_addr == '0):           rb_data = '0;
      (wr && wb_addr == rb_addr): rb_data = wb_data;
      default:                   rb_data = mem[rb_addr];
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-issue stage ahead of the ALU: GRF read, bypass, immediate
// select and a one-entry valid/ready output register.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int ADDR_W = alu_pkg::ADDR_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [OP_W-1:0]   in_aluop,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OP_W-1:0]   out_aluop
);

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] b_sel;
  logic              accept;
  logic              drain;

  grf_core #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_grf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (in_rs),
    .ra_data (rs_data),
    .rb_addr (in_rt),
    .rb_data (rt_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready && !accept;
  assign b_sel    = in_use_imm ? in_imm : rt_data;

  // Held entries are a snapshot; later writebacks do not touch them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_aluop <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          out_valid <= 1'b1;
          out_a     <= rs_data;
          out_b     <= b_sel;
          out_aluop <= in_aluop;
        end
        drain:   out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_aluop;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_aluop;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_aluop   (in_aluop),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_aluop  (out_aluop)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic ui, input logic [31:0] imm,
                       input logic [2:0] op);
    in_valid   = 1'b1;
    in_rs      = rs;
    in_rt      = rt;
    in_use_imm = ui;
    in_imm     = imm;
    in_aluop   = op;
  endtask

  task automatic wb(input logic en, input logic [4:0] a,
                    input logic [31:0] d);
    wb_en   = en;
    wb_addr = a;
    wb_data = d;
  endtask

  logic [2:0] ops [4];

  initial begin
    ops[0] = 3'b000; ops[1] = 3'b001;
    ops[2] = 3'b101; ops[3] = 3'b111;

    // Reset with writeback and issue active: both ignored
    rst_n = 1'b0;
    out_ready = 1'b1;
    wb(1'b1, 5'd3, 32'hFFFF_FFFF);
    issue(5'd3, 5'd3, 1'b0, 32'h0, 3'b010);
    tick();
    tick();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_a", out_a, 32'd0);
    check("rst_b", out_b, 32'd0);
    check("rst_op", {29'b0, out_aluop}, 32'd0);

    rst_n = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    #1;
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("r3_after_rst_a", out_a, 32'd0);
    check("r3_after_rst_b", out_b, 32'd0);
    check("r3_op", {29'b0, out_aluop}, 32'd2);
    in_valid = 1'b0;

    // Plain write then read
    wb(1'b1, 5'd5, 32'h1234_5678);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(5'd5, 5'd0, 1'b0, 32'h0, 3'b000);
    tick();
    check("wr_valid", {31'b0, out_valid}, 32'd1);
    check("wr_a", out_a, 32'h1234_5678);
    check("wr_b", out_b, 32'd0);

    // Same-cycle bypass on both ports
    wb(1'b1, 5'd7, 32'hDEAD_BEEF);
    issue(5'd7, 5'd7, 1'b0, 32'h0, 3'b011);
    tick();
    check("byp_a", out_a, 32'hDEAD_BEEF);
    check("byp_b", out_b, 32'hDEAD_BEEF);
    check("byp_op", {29'b0, out_aluop}, 32'd3);
    wb(1'b0, 5'd0, 32'h0);
    in_valid = 1'b0;
    tick();
    check("drain_valid", {31'b0, out_valid}, 32'd0);
    check("drain_keep_a", out_a, 32'hDEAD_BEEF);

    // Zero register: write dropped, no bypass, immediate on B
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    issue(5'd0, 5'd7, 1'b1, 32'h8, 3'b001);
    tick();
    check("zero_a", out_a, 32'd0);
    check("zero_b", out_b, 32'h8);
    wb(1'b0, 5'd0, 32'h0);

    // Immediate select ignores an rt bypass
    wb(1'b1, 5'd7, 32'h77);
    issue(5'd5, 5'd7, 1'b1, 32'h55, 3'b100);
    tick();
    check("imm_a", out_a, 32'h1234_5678);
    check("imm_b", out_b, 32'h55);
    wb(1'b0, 5'd0, 32'h0);
    in_valid = 1'b0;

    // Backpressure: held snapshot not refreshed
    wb(1'b1, 5'd3, 32'd3);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    out_ready = 1'b0;
    issue(5'd3, 5'd0, 1'b1, 32'h1, 3'b100);
    tick();
    check("bp_a0", out_a, 32'd3);
    issue(5'd3, 5'd3, 1'b0, 32'h0, 3'b101);
    wb(1'b1, 5'd3, 32'd9);
    #1;
    check("bp_ready", {31'b0, in_ready}, 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    check("bp_a1", out_a, 32'd3);
    check("bp_op1", {29'b0, out_aluop}, 32'd4);
    tick();
    check("bp_a2", out_a, 32'd3);
    out_ready = 1'b1;
    #1;
    check("bp_ready2", {31'b0, in_ready}, 32'd1);
    tick();
    check("bp_new_valid", {31'b0, out_valid}, 32'd1);
    check("bp_new_a", out_a, 32'd9);
    check("bp_new_b", out_b, 32'd9);
    check("bp_new_op", {29'b0, out_aluop}, 32'd5);

    // Back-to-back throughput
    for (int i = 0; i < 4; i++) begin
      issue(5'd5, 5'd3, 1'b0, 32'h0, ops[i]);
      tick();
      check("tp_valid", {31'b0, out_valid}, 32'd1);
      check("tp_op", {29'b0, out_aluop}, {29'b0, ops[i]});
    end
    in_valid = 1'b0;
    tick();
    check("tp_end_valid", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
